// File: rtl/bus_arb_pkg.sv
// Shared definitions for the uio bus arbiter: state encoding, default hold limit, clog2 helper.
package bus_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  localparam int MAX_HOLD_DEF = 15;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_arb_sched_if.sv
// Request/grant bundle between the uio requesters (master) and the arbiter (slave).
interface bus_arb_sched_if
  import bus_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2(NREQ)
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] done;
  logic            lock;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            bus_oe;
  logic            busy;
  logic            timeout_err;

  modport master (
    output req, done, lock,
    input  gnt, gnt_id, bus_oe, busy, timeout_err
  );

  modport slave (
    input  req, done, lock,
    output gnt, gnt_id, bus_oe, busy, timeout_err
  );
endinterface

// File: rtl/bus_arb_rr_pick.sv
// Combinational round-robin pick: first set req scanning ptr+1, ptr+2, ... modulo NREQ.
module bus_arb_rr_pick
  import bus_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IDW-1:0]  idx,
  output logic            valid
);

  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/bus_arb_sched.sv
// Round-robin uio bus arbiter with turnaround cycle; hold-time limit built with BUS_ARB_TIMEOUT_EN.
module bus_arb_sched
  import bus_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int HOLD_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  bus_arb_sched_if.slave    bus
);

  // state | meaning
  // IDLE  | bus free, arbitrate on any req
  // GRANT | one owner drives the bus
  // TURN  | dead cycle after release, arbitrate again

  localparam int IDW = clog2(NREQ);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [1:0]      state, state_nxt;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  rr_ptr, rr_ptr_d;
  logic            tmo_q, tmo_d;
  logic [NREQ-1:0] pick_onehot;
  logic [IDW-1:0]  pick_idx;
  logic            pick_valid;
  logic            rel_norm, timeout_hit, leave;

  bus_arb_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req    (bus.req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign rel_norm = bus.done[id_q] | ~bus.req[id_q];

`ifdef BUS_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt;

  // Counter is only meaningful in GRANT; it restarts at 0 on every new tenure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state != ST_GRANT) begin
      hold_cnt <= '0;
    end else if (!bus.lock && hold_cnt != HOLD_W'(MAX_HOLD)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == ST_GRANT) && (hold_cnt == HOLD_LAST) && !bus.lock && !rel_norm;
`else
  logic unused_cfg;
  assign unused_cfg  = ^{bus.lock, HOLD_LAST};
  assign timeout_hit = 1'b0;
`endif

  assign leave = rel_norm | timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      gnt_q  <= '0;
      id_q   <= '0;
      rr_ptr <= IDW'(NREQ - 1);
      tmo_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      gnt_q  <= gnt_d;
      id_q   <= id_d;
      rr_ptr <= rr_ptr_d;
      tmo_q  <= tmo_d;
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:  state_nxt = pick_valid ? ST_GRANT : ST_IDLE;
      ST_GRANT: state_nxt = leave ? ST_TURN : ST_GRANT;
      ST_TURN:  state_nxt = pick_valid ? ST_GRANT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_d    = gnt_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr;
    tmo_d    = 1'b0;
    case (state)
      ST_GRANT: begin
        if (leave) begin
          gnt_d    = '0;
          rr_ptr_d = id_q;
          tmo_d    = timeout_hit;
        end
      end
      ST_IDLE, ST_TURN: begin
        gnt_d = pick_onehot;
        if (pick_valid) id_d = pick_idx;
      end
      default: gnt_d = '0;
    endcase
  end

  assign bus.gnt         = gnt_q;
  assign bus.gnt_id      = id_q;
  assign bus.bus_oe      = |gnt_q;
  assign bus.busy        = (state == ST_GRANT);
  assign bus.timeout_err = tmo_q;

endmodule
